// File: rtl/io_arbiter.sv
// -----------------------------------------------------------------------------
// io_arbiter
//   Shares the single io port between NUM_REQ requesters (CPU pst/pld path,
//   debug/loader, future DMA). Round-robin arbitration, one transaction in
//   flight at a time, all outputs registered. Read data is returned with a
//   one-cycle completion pulse on done.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   req          level request per requester
//   req_write    1=write, 0=read, per requester
//   req_addr     packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_wdata    packed write data, requester i at [i*DATA_W +: DATA_W]
//   gnt          one-hot, high for exactly the ACCESS cycle
//   done         one-hot completion pulse
//   rdata        read data, valid with done, held until the next read capture
//   busy         high whenever the FSM is not IDLE
//   io_addr      io address (held outside ACCESS/WAIT)
//   io_data      io write data (held outside ACCESS/WAIT)
//   io_write     io write strobe, high only in ACCESS of a write
//   io_data_out  io read data
//
// State  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no transaction; pick the next requester round-robin
// ACCESS | io port driven with latched operands for one cycle
// WAIT   | read latency countdown, io_addr held
// DONE   | done pulse to the granted requester
// -----------------------------------------------------------------------------
module io_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int READ_LAT = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [NUM_REQ-1:0]          done,
  output logic [DATA_W-1:0]           rdata,
  output logic                        busy,
  output logic [ADDR_W-1:0]           io_addr,
  output logic [DATA_W-1:0]           io_data,
  output logic                        io_write,
  input  logic [DATA_W-1:0]           io_data_out
);

  localparam int         IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [3:0] LAT_INIT = 4'(READ_LAT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                wr_q, wr_d;
  logic [3:0]          lat_q, lat_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic                busy_q, busy_d;
  logic                io_write_q, io_write_d;
  logic [ADDR_W-1:0]   io_addr_q, io_addr_d;
  logic [DATA_W-1:0]   io_data_q, io_data_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic                found;
  logic [IDX_W-1:0]    sel;
  logic [IDX_W-1:0]    cand;

  // Round-robin pick: scan from last+1 upward with wrap. Iterating the
  // offset downward lets the nearest candidate overwrite farther ones.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IDX_W'((int'(last_q) + k) % NUM_REQ);
      if (req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  // Outputs are registered, so they are computed from the state being entered.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    idx_d      = idx_q;
    wr_d       = wr_q;
    lat_d      = lat_q;
    gnt_d      = '0;
    done_d     = '0;
    io_write_d = 1'b0;
    io_addr_d  = io_addr_q;
    io_data_d  = io_data_q;
    rdata_d    = rdata_q;

    case (state_q)
      IDLE: begin
        if (found) begin
          state_d    = ACCESS;
          idx_d      = sel;
          last_d     = sel;
          wr_d       = req_write[sel];
          lat_d      = LAT_INIT;
          io_addr_d  = req_addr[int'(sel)*ADDR_W +: ADDR_W];
          io_data_d  = req_wdata[int'(sel)*DATA_W +: DATA_W];
          io_write_d = req_write[sel];
          gnt_d[sel] = 1'b1;
        end
      end
      ACCESS: begin
        if (wr_q) begin
          state_d       = DONE;
          done_d[idx_q] = 1'b1;
        end else if (lat_q == 4'd0) begin
          rdata_d       = io_data_out;
          state_d       = DONE;
          done_d[idx_q] = 1'b1;
        end else begin
          lat_d   = lat_q - 4'd1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (lat_q == 4'd0) begin
          rdata_d       = io_data_out;
          state_d       = DONE;
          done_d[idx_q] = 1'b1;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_q     <= IDX_W'(NUM_REQ - 1);
      idx_q      <= '0;
      wr_q       <= 1'b0;
      lat_q      <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      busy_q     <= 1'b0;
      io_write_q <= 1'b0;
      io_addr_q  <= '0;
      io_data_q  <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      idx_q      <= idx_d;
      wr_q       <= wr_d;
      lat_q      <= lat_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      io_write_q <= io_write_d;
      io_addr_q  <= io_addr_d;
      io_data_q  <= io_data_d;
      rdata_q    <= rdata_d;
    end
  end

  assign gnt      = gnt_q;
  assign done     = done_q;
  assign busy     = busy_q;
  assign io_write = io_write_q;
  assign io_addr  = io_addr_q;
  assign io_data  = io_data_q;
  assign rdata    = rdata_q;

endmodule
